// File: rtl/uart_pkg.sv
// Shared types and constants for the UART flow-control slice: TX state enum,
// active-low pin levels and a parameter-legality check used at elaboration.
package uart_pkg;

    typedef enum logic {
        TX_HOLD = 1'b0,
        TX_RUN  = 1'b1
    } tx_state_t;

    localparam logic PIN_ASSERT   = 1'b0;
    localparam logic PIN_DEASSERT = 1'b1;

    function automatic bit flow_params_ok(input int lvl_w, input int hi_wm, input int lo_wm,
                                          input int sync_stages, input int cts_guard);
        return (lo_wm >= 0) && (lo_wm < hi_wm) && (hi_wm <= (2 ** lvl_w) - 1) &&
               (sync_stages >= 2) && (cts_guard >= 1);
    endfunction

endpackage

// File: rtl/uart_sync_filter.sv
// Multi-flop synchroniser followed by a stability filter: the output only follows
// the synchronised input after CTS_GUARD consecutive cycles of disagreement.
module uart_sync_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CTS_GUARD   = 4,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int GW = (CTS_GUARD > 1) ? $clog2(CTS_GUARD) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(CTS_GUARD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [GW-1:0]          guard_cnt;
    logic                   din_sync;

    assign din_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Any cycle of agreement restarts the guard window, so short pulses die here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_cnt <= '0;
            dout      <= RST_VAL;
        end else if (din_sync == dout) begin
            guard_cnt <= '0;
        end else if (guard_cnt == GUARD_LAST) begin
            guard_cnt <= '0;
            dout      <= din_sync;
        end else begin
            guard_cnt <= guard_cnt + GW'(1);
        end
    end

endmodule

// File: rtl/uart_flow_ctrl.sv
// RTS/CTS flow control: RTS from RX FIFO level with hysteresis, TX start gating
// from filtered CTS. Optional CTS watchdog under UART_FLOW_CTS_TIMEOUT_EN.
//
// TX FSM   state   | meaning
//          TX_HOLD | peer not ready (or just reset), enable_tx=0
//          TX_RUN  | peer ready or bypass, enable_tx=1
// RTS FSM is the rts register itself: 0 = ready to receive, 1 = throttle peer.
module uart_flow_ctrl
    import uart_pkg::*;
#(
    parameter int LVL_W       = 5,
    parameter int HI_WM       = 12,
    parameter int LO_WM       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CTS_GUARD   = 4
`ifdef UART_FLOW_CTS_TIMEOUT_EN
    ,parameter int TMO_CYC    = 1_000_000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cts,
    input  logic [LVL_W-1:0] rx_level,
    input  logic             rx_full,
    input  logic             rx_empty,
    output logic             rts,
    output logic             enable_tx,
`ifdef UART_FLOW_CTS_TIMEOUT_EN
    input  logic             timeout_clr,
    output logic             cts_timeout,
`endif
    output logic             cts_filt
);

    localparam logic [LVL_W-1:0] HI_LVL = LVL_W'(HI_WM);
    localparam logic [LVL_W-1:0] LO_LVL = LVL_W'(LO_WM);

    if (!flow_params_ok(LVL_W, HI_WM, LO_WM, SYNC_STAGES, CTS_GUARD)) begin : g_param_err
        $error("uart_flow_ctrl: illegal parameter combination");
    end

    tx_state_t tx_state;
    tx_state_t tx_nxt;
    logic      rts_nxt;

    uart_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .CTS_GUARD   (CTS_GUARD),
        .RST_VAL     (PIN_DEASSERT)
    ) u_cts_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cts),
        .dout  (cts_filt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts      <= PIN_ASSERT;
            tx_state <= TX_HOLD;
        end else begin
            rts      <= rts_nxt;
            tx_state <= tx_nxt;
        end
    end

    always_comb begin
        rts_nxt = rts;
        tx_nxt  = tx_state;
        if (!enable) begin
            rts_nxt = PIN_ASSERT;
            tx_nxt  = TX_RUN;
        end else begin
            // rx_full ahead of rx_empty so an illegal full+empty throttles the peer.
            if (rx_full)                 rts_nxt = PIN_DEASSERT;
            else if (rx_empty)           rts_nxt = PIN_ASSERT;
            else if (rx_level >= HI_LVL) rts_nxt = PIN_DEASSERT;
            else if (rx_level <= LO_LVL) rts_nxt = PIN_ASSERT;

            case (tx_state)
                TX_HOLD: if (cts_filt == PIN_ASSERT)   tx_nxt = TX_RUN;
                TX_RUN:  if (cts_filt == PIN_DEASSERT) tx_nxt = TX_HOLD;
                default: tx_nxt = TX_HOLD;
            endcase
        end
    end

    assign enable_tx = (tx_state == TX_RUN);

`ifdef UART_FLOW_CTS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC);

    logic [TMO_W-1:0] tmo_cnt;

    // Counter saturates at the threshold; the flag is sticky until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            cts_timeout <= 1'b0;
        end else if (timeout_clr) begin
            tmo_cnt     <= '0;
            cts_timeout <= 1'b0;
        end else if (enable && (cts_filt == PIN_DEASSERT)) begin
            if (tmo_cnt != TMO_LAST) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
                if (tmo_cnt == TMO_LAST - TMO_W'(1)) cts_timeout <= 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_flow_ctrl.sv
// Self-checking bench for uart_flow_ctrl: table-driven RTS vectors plus hand-written
// CTS latency, glitch, bypass, mid-operation reset and (with the macro) watchdog sequences.
module tb_uart_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       cts;
    logic [4:0] rx_level;
    logic       rx_full;
    logic       rx_empty;
    logic       rts;
    logic       enable_tx;
    logic       cts_filt;
`ifdef UART_FLOW_CTS_TIMEOUT_EN
    logic       timeout_clr;
    logic       cts_timeout;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_flow_ctrl #(
        .LVL_W       (5),
        .HI_WM       (12),
        .LO_WM       (4),
        .SYNC_STAGES (2),
        .CTS_GUARD   (4)
`ifdef UART_FLOW_CTS_TIMEOUT_EN
        ,.TMO_CYC    (20)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cts         (cts),
        .rx_level    (rx_level),
        .rx_full     (rx_full),
        .rx_empty    (rx_empty),
        .rts         (rts),
        .enable_tx   (enable_tx),
`ifdef UART_FLOW_CTS_TIMEOUT_EN
        .timeout_clr (timeout_clr),
        .cts_timeout (cts_timeout),
`endif
        .cts_filt    (cts_filt)
    );

    typedef struct {
        logic       en;
        logic       full;
        logic       empty;
        logic [4:0] lvl;
        logic       rts;
        logic       etx;
        logic       filt;
    } vec_t;

    typedef struct {
        string name;
        logic  rts;
        logic  etx;
        logic  filt;
    } exp_t;

    vec_t hyst_v[$];
    vec_t byp_v[$];
    exp_t sb[$];

    task automatic expect_edge(input string nm, input logic r, input logic e, input logic f);
        exp_t x;
        x.name = nm;
        x.rts  = r;
        x.etx  = e;
        x.filt = f;
        sb.push_back(x);
    endtask

    // One clock edge, then compare outputs against the oldest expectation.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued for edge at t=%0t", $time);
        end else begin
            x = sb.pop_front();
            if (rts !== x.rts || enable_tx !== x.etx || cts_filt !== x.filt) begin
                errors++;
                $display("FAIL %s: got rts/enable_tx/cts_filt=%b/%b/%b want %b/%b/%b",
                         x.name, rts, enable_tx, cts_filt, x.rts, x.etx, x.filt);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        enable   = v.en;
        rx_full  = v.full;
        rx_empty = v.empty;
        rx_level = v.lvl;
        expect_edge(nm, v.rts, v.etx, v.filt);
        tick();
    endtask

    initial begin
        // Hysteresis table, cts held asserted (enable_tx=1, cts_filt=0).
        for (int l = 0; l <= 16; l++)
            hyst_v.push_back('{1'b1, (l == 16), (l == 0), 5'(l), (l >= 12), 1'b1, 1'b0});
        for (int l = 15; l >= 0; l--)
            hyst_v.push_back('{1'b1, 1'b0, (l == 0), 5'(l), (l > 4), 1'b1, 1'b0});
        hyst_v.push_back('{1'b1, 1'b1, 1'b0, 5'd8,  1'b1, 1'b1, 1'b0});
        hyst_v.push_back('{1'b1, 1'b0, 1'b0, 5'd8,  1'b1, 1'b1, 1'b0});
        hyst_v.push_back('{1'b1, 1'b0, 1'b0, 5'd3,  1'b0, 1'b1, 1'b0});
        hyst_v.push_back('{1'b1, 1'b0, 1'b0, 5'd8,  1'b0, 1'b1, 1'b0});
        hyst_v.push_back('{1'b1, 1'b1, 1'b1, 5'd8,  1'b1, 1'b1, 1'b0});
        hyst_v.push_back('{1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0});
        // Bypass table, cts held deasserted.
        byp_v.push_back('{1'b1, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1});
        byp_v.push_back('{1'b0, 1'b0, 1'b0, 5'd13, 1'b0, 1'b1, 1'b1});
        byp_v.push_back('{1'b0, 1'b1, 1'b0, 5'd16, 1'b0, 1'b1, 1'b1});
        byp_v.push_back('{1'b1, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1});

        rst_n    = 1'b0;
        enable   = 1'b1;
        cts      = 1'b1;
        rx_level = 5'd0;
        rx_full  = 1'b0;
        rx_empty = 1'b1;
`ifdef UART_FLOW_CTS_TIMEOUT_EN
        timeout_clr = 1'b0;
`endif

        // Reset and hold with cts deasserted.
        #12;
        chk("reset_rts", rts, 1'b0);
        chk("reset_enable_tx", enable_tx, 1'b0);
        chk("reset_cts_filt", cts_filt, 1'b1);
`ifdef UART_FLOW_CTS_TIMEOUT_EN
        chk("reset_cts_timeout", cts_timeout, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) expect_edge($sformatf("reset_hold_%0d", n), 1'b0, 1'b0, 1'b1);
        repeat (10) tick();

        // CTS assert then deassert latency.
        @(negedge clk);
        cts = 1'b0;
        for (int n = 1; n <= 7; n++)
            expect_edge($sformatf("cts_fall_edge%0d", n), 1'b0, (n >= 7), (n >= 6) ? 1'b0 : 1'b1);
        repeat (7) tick();
        @(negedge clk);
        cts = 1'b1;
        for (int n = 1; n <= 7; n++)
            expect_edge($sformatf("cts_rise_edge%0d", n), 1'b0, (n < 7), (n >= 6) ? 1'b1 : 1'b0);
        repeat (7) tick();
        idle(3);

        // 3-cycle glitch rejected.
        @(negedge clk);
        cts = 1'b0;
        for (int n = 1; n <= 12; n++) expect_edge($sformatf("glitch3_edge%0d", n), 1'b0, 1'b0, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 3) begin
                @(negedge clk);
                cts = 1'b1;
            end
        end

        // 4-cycle pulse accepted: cts_filt low on edges 6..9, enable_tx high on 7..10.
        @(negedge clk);
        cts = 1'b0;
        for (int n = 1; n <= 12; n++)
            expect_edge($sformatf("pulse4_edge%0d", n), 1'b0, (n >= 7 && n <= 10),
                        (n >= 6 && n <= 9) ? 1'b0 : 1'b1);
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 4) begin
                @(negedge clk);
                cts = 1'b1;
            end
        end

        // Hysteresis with cts asserted.
        @(negedge clk);
        cts = 1'b0;
        idle(10);
        for (int i = 0; i < hyst_v.size(); i++)
            apply(hyst_v[i], $sformatf("hyst_%0d_lvl%0d", i, hyst_v[i].lvl));

        // Bypass with rts throttled and cts deasserted.
        @(negedge clk);
        cts      = 1'b1;
        rx_level = 5'd13;
        rx_empty = 1'b0;
        rx_full  = 1'b0;
        idle(10);
        for (int i = 0; i < byp_v.size(); i++)
            apply(byp_v[i], $sformatf("bypass_%0d", i));

        // Asynchronous reset while transmitting, then full latency before TX resumes.
        @(negedge clk);
        rx_level = 5'd0;
        rx_empty = 1'b1;
        cts      = 1'b0;
        idle(10);
        chk("pre_reset_enable_tx", enable_tx, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_rts", rts, 1'b0);
        chk("midreset_enable_tx", enable_tx, 1'b0);
        chk("midreset_cts_filt", cts_filt, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 7; n++)
            expect_edge($sformatf("post_reset_edge%0d", n), 1'b0, (n >= 7), (n >= 6) ? 1'b0 : 1'b1);
        repeat (7) tick();

`ifdef UART_FLOW_CTS_TIMEOUT_EN
        // cts_filt rises on edge 6, 20 counted edges later the flag sets (edge 26).
        @(negedge clk);
        cts = 1'b1;
        idle(25);
        chk("timeout_before_threshold", cts_timeout, 1'b0);
        idle(1);
        chk("timeout_at_threshold", cts_timeout, 1'b1);
        idle(14);
        chk("timeout_sticky", cts_timeout, 1'b1);
        @(negedge clk);
        timeout_clr = 1'b1;
        cts         = 1'b0;
        idle(1);
        chk("timeout_cleared", cts_timeout, 1'b0);
        @(negedge clk);
        timeout_clr = 1'b0;
        idle(40);
        chk("timeout_never_sets", cts_timeout, 1'b0);
`endif

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_leftover: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_flow_ctrl.md
# uart_flow_ctrl

Parametrised RTS/CTS hardware flow-control block for the UART, placed between the RX FIFO, the TX serializer and the modem pins. Drives RTS from the RX FIFO fill level with programmable hysteresis watermarks, and gates TX frame starts from a synchronised, glitch-filtered CTS. An optional watchdog flags a peer that holds CTS deasserted too long.

## Interface
- `LVL_W`, 5: width of the RX FIFO level input; a 16-deep FIFO needs 5 bits (0..16).
- `HI_WM`, 12: level at or above which RTS is deasserted. Must satisfy `LO_WM < HI_WM <= 2**LVL_W-1`.
- `LO_WM`, 4: level at or below which RTS is reasserted.
- `SYNC_STAGES`, 2: CTS synchroniser depth; must be ≥2.
- `CTS_GUARD`, 4: consecutive stable synchronised cycles required before the filtered CTS changes; must be ≥1.
- `TMO_CYC`, 1_000_000: CTS-deasserted cycles before a timeout is flagged (macro only).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = flow control active; 0 = bypass.
- `cts` in 1: modem CTS pin, active low, asynchronous to `clk`.
- `rx_level` in LVL_W: RX FIFO occupancy.
- `rx_full` in 1: RX FIFO full.
- `rx_empty` in 1: RX FIFO empty.
- `rts` out 1: modem RTS pin, active low (0 = ready to receive).
- `enable_tx` out 1: 1 = TX may start a new frame.
- `cts_filt` out 1: filtered CTS, active low.
- `timeout_clr` in 1: clears `cts_timeout` (macro only).
- `cts_timeout` out 1: sticky watchdog flag (macro only).

## Operation
- **Reset values:** `rts`=0, `enable_tx`=0, `cts_filt`=1, all synchroniser flops=1, guard counter=0, `cts_timeout`=0.
- **Sync/filter:** `cts` passes through `SYNC_STAGES` flops.
  - A guard counter increments each cycle the synchronised value differs from `cts_filt`.
  - The counter clears to 0 on any cycle they match.
  - When the counter is at `CTS_GUARD-1` and they still differ, `cts_filt` takes the new value and the counter clears.
  - Pulses shorter than `CTS_GUARD` synchronised cycles never reach `cts_filt`.
  - Sync and filter keep running while `enable`=0.
- **RTS FSM** (state is the `rts` register). Priority, evaluated each edge with `enable`=1:
  1. `rx_full` → `rts`=1.
  2. `rx_empty` → `rts`=0.
  3. `rx_level >= HI_WM` → `rts`=1.
  4. `rx_level <= LO_WM` → `rts`=0.
  5. Otherwise hold.
- If `rx_full` and `rx_empty` are both asserted (illegal), `rx_full` wins.
- **TX FSM:** two states. `TX_HOLD` drives `enable_tx`=0; `TX_RUN` drives `enable_tx`=1.
  - `TX_HOLD`→`TX_RUN` when `cts_filt`=0.
  - `TX_RUN`→`TX_HOLD` when `cts_filt`=1.
  - A frame already in flight is finished by the serializer; this block only gates frame starts.
- **Bypass** (`enable`=0): next edge gives `rts`=0 and `enable_tx`=1, regardless of level or CTS.
  - On returning to `enable`=1, both FSMs re-evaluate from current inputs at the next edge.
- **Reset mid-operation:** all state returns immediately to the reset values. TX stays held until CTS is seen asserted for the full filter latency.

## Timing
- **CTS → `enable_tx`:** a `cts` edge sampled at clock edge k reaches `cts_filt` at edge k+SYNC_STAGES+CTS_GUARD-1. It reaches `enable_tx` one edge later. Defaults: 6 edges to `cts_filt`, 7 to `enable_tx`.
- **Level/full/empty → `rts`:** 1 edge, registered, no combinational paths to outputs.
- **`enable` → outputs:** 1 edge.

## Configuration
- `UART_FLOW_CTS_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TMO_CYC+1)` increments while `enable`=1 and `cts_filt`=1; otherwise it clears.
  - On reaching `TMO_CYC`, the counter saturates and `cts_timeout` sets on that edge.
  - `cts_timeout` stays set until `timeout_clr`=1, which clears both flag and counter.
  - If `timeout_clr` arrives on the same edge the threshold is hit, clear wins.
- Macro undefined: the counter, `timeout_clr` and `cts_timeout` ports are absent. All other behaviour is identical.

## Structure
- `uart_pkg` holds:
  - the TX FSM state enum (`TX_HOLD`, `TX_RUN`);
  - the shared active-low pin-level constants (`PIN_ASSERT`=0, `PIN_DEASSERT`=1);
  - elaboration checks for the parameter constraints.
- Sub-module `uart_sync_filter` (parameters `SYNC_STAGES`, `CTS_GUARD`, reset value 1) is reused later for the RX pin and a break detector. RTS/TX FSMs and the watchdog stay in the top module.

## Test plan
All scenarios use defaults (`LVL_W`=5, `HI_WM`=12, `LO_WM`=4, `SYNC_STAGES`=2, `CTS_GUARD`=4).
- **Reset:** `rst_n` low, then release with `cts`=1 → `rts`=0, `enable_tx`=0, `cts_filt`=1, held indefinitely.
- **CTS latency:** `cts` 1→0 → `cts_filt`=0 exactly 6 edges later and `enable_tx`=1 at 7. Then `cts` 0→1 → `enable_tx`=0 after 7.
- **Glitch rejection:** 3-cycle low pulse on `cts` → `cts_filt` and `enable_tx` unchanged. A 4-cycle pulse → accepted.
- **Hysteresis:** ramp `rx_level` 0→16 → `rts`=1 from level 12. Ramp back down → `rts` stays 1 through levels 11..5 and goes 0 at level 4. `rx_full` at level 8 → `rts`=1 next edge.
- **Bypass:** `enable`=0 while `rts`=1 and `cts`=1 → next edge `rts`=0, `enable_tx`=1. Re-enable with level 13 → `rts`=1 next edge.
- **Timeout (macro on, `TMO_CYC`=20):** hold `cts`=1 → `cts_timeout`=1 after 20 counted cycles and stays set. `timeout_clr` pulse → `cts_timeout`=0. Assert `cts` before the threshold → never sets.
